// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache line fetcher (burst constants, beat payload, clogb2).
package cache_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int unsigned LINE_BEAT_DW = 512;

  typedef struct packed {
    logic [LINE_BEAT_DW-1:0] data;
    logic                    last;
  } line_beat_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned r = 0;
    while ((64'd1 << r) < 64'(value)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/cache_line_fetcher_if.sv
// AXI4 read address/data channel bundle between the line fetcher (master) and memory (slave).
interface cache_line_fetcher_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 512
) ();

  logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]                m_axi_arlen;
  logic [2:0]                m_axi_arsize;
  logic [1:0]                m_axi_arburst;
  logic                      m_axi_arid;
  logic                      m_axi_arvalid;
  logic                      m_axi_arready;
  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]                m_axi_rresp;
  logic                      m_axi_rlast;
  logic                      m_axi_rvalid;
  logic                      m_axi_rready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
           m_axi_arvalid, m_axi_rready,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
           m_axi_arvalid, m_axi_rready,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
  );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry valid/ready FIFO; output data comes straight from the storage registers.
module fetch_skid_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

endmodule

// File: rtl/cache_line_fetcher.sv
// Turns cache miss tags into single-ID AXI4 INCR line bursts and streams the line back in order.
// Optional CACHE_FETCH_ERR_EN adds err_sticky/err_count for bad rresp or misplaced rlast.
module cache_line_fetcher
  import cache_pkg::*;
#(
  parameter int unsigned TAGS_WIDTH      = 48,
  parameter int unsigned CACHE_SIZE      = 512,
  parameter int unsigned DATA_PORT_SIZE  = 512,
  parameter int unsigned AXI_DATA_WIDTH  = 512,
  parameter int unsigned AXI_ADDR_WIDTH  = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_tvalid,
  output logic                      req_tready,
  input  logic [TAGS_WIDTH-1:0]     req_tdata,
  output logic                      line_tvalid,
  input  logic                      line_tready,
  output logic [DATA_PORT_SIZE-1:0] line_tdata,
  output logic                      line_tlast,
  cache_line_fetcher_if.master      axi,
  output logic [3:0]                outstanding
`ifdef CACHE_FETCH_ERR_EN
  ,
  output logic                      err_sticky,
  output logic [15:0]               err_count
`endif
);

  localparam int unsigned BEATS       = ((CACHE_SIZE / AXI_DATA_WIDTH) == 0) ? 1 : (CACHE_SIZE / AXI_DATA_WIDTH);
  localparam int unsigned LINE_SHIFT  = clogb2(CACHE_SIZE / 8);
  localparam int unsigned BEAT_W      = (BEATS > 1) ? clogb2(BEATS) : 1;
  localparam int unsigned ADDR_FULL_W = TAGS_WIDTH + LINE_SHIFT;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [3:0]        MAX_OUT   = 4'(MAX_OUTSTANDING);
  localparam logic [7:0]        AR_LEN    = 8'(BEATS - 1);
  localparam logic [2:0]        AR_SIZE   = 3'(clogb2(AXI_DATA_WIDTH / 8));

  logic [ADDR_FULL_W-1:0] line_addr;
  logic                   ar_fire;
  logic                   r_fire;
  logic                   out_dec;
  logic                   fifo_in_ready;
  logic [BEAT_W-1:0]      beat_cnt;
  logic                   beat_last;
  line_beat_t             push_beat;
  line_beat_t             pop_beat;

  assign line_addr  = ADDR_FULL_W'(req_tdata) << LINE_SHIFT;
  assign req_tready = rstn & (~axi.m_axi_arvalid | axi.m_axi_arready) & (outstanding < MAX_OUT);
  assign ar_fire    = req_tvalid & req_tready;
  assign r_fire     = axi.m_axi_rvalid & axi.m_axi_rready;
  assign out_dec    = r_fire & axi.m_axi_rlast & (outstanding != 4'd0);
  assign beat_last  = (beat_cnt == LAST_BEAT);

  assign axi.m_axi_arid   = 1'b0;
  assign axi.m_axi_rready = rstn & fifo_in_ready;

  // Single-entry AR register; a new tag may load in the same cycle the old one handshakes.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      axi.m_axi_arvalid <= 1'b0;
      axi.m_axi_araddr  <= '0;
      axi.m_axi_arlen   <= '0;
      axi.m_axi_arsize  <= '0;
      axi.m_axi_arburst <= '0;
    end else if (ar_fire) begin
      axi.m_axi_arvalid <= 1'b1;
      axi.m_axi_araddr  <= AXI_ADDR_WIDTH'(line_addr);
      axi.m_axi_arlen   <= AR_LEN;
      axi.m_axi_arsize  <= AR_SIZE;
      axi.m_axi_arburst <= AXI_BURST_INCR;
    end else if (axi.m_axi_arready) begin
      axi.m_axi_arvalid <= 1'b0;
    end
  end

  // In-flight count; a stray rlast with nothing outstanding is ignored.
  always_ff @(posedge clk) begin
    if (!rstn)                  outstanding <= 4'd0;
    else if (ar_fire && !out_dec) outstanding <= outstanding + 4'd1;
    else if (!ar_fire && out_dec) outstanding <= outstanding - 4'd1;
  end

  // tlast follows the local beat position, not rlast.
  always_ff @(posedge clk) begin
    if (!rstn)       beat_cnt <= '0;
    else if (r_fire) beat_cnt <= beat_last ? '0 : beat_cnt + BEAT_W'(1);
  end

  assign push_beat = '{data: LINE_BEAT_DW'(axi.m_axi_rdata), last: beat_last};

  fetch_skid_fifo #(
    .WIDTH ($bits(line_beat_t))
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (r_fire),
    .in_ready  (fifo_in_ready),
    .in_data   (push_beat),
    .out_valid (line_tvalid),
    .out_ready (line_tready),
    .out_data  (pop_beat)
  );

  assign line_tdata = DATA_PORT_SIZE'(pop_beat.data);
  assign line_tlast = line_tvalid & pop_beat.last;

`ifdef CACHE_FETCH_ERR_EN
  logic beat_err;
  assign beat_err = r_fire & ((axi.m_axi_rresp != AXI_RESP_OKAY) | (axi.m_axi_rlast != beat_last));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_sticky <= 1'b0;
      err_count  <= 16'd0;
    end else if (beat_err) begin
      err_sticky <= 1'b1;
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^axi.m_axi_rresp;
`endif

endmodule

// File: tb/tb_cache_line_fetcher.sv
// Directed scoreboard bench for cache_line_fetcher: one 1-beat-line instance and one 4-beat-line instance.
module tb_cache_line_fetcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [511:0] data;
    logic         last;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   idx4;

  logic         req_tvalid1, req_tready1, line_tvalid1, line_tready1, line_tlast1;
  logic [47:0]  req_tdata1;
  logic [511:0] line_tdata1;
  logic [3:0]   outstanding1;
  logic         req_tvalid4, req_tready4, line_tvalid4, line_tready4, line_tlast4;
  logic [47:0]  req_tdata4;
  logic [511:0] line_tdata4;
  logic [3:0]   outstanding4;
`ifdef CACHE_FETCH_ERR_EN
  logic         err_sticky1, err_sticky4;
  logic [15:0]  err_count1, err_count4;
`endif

  cache_line_fetcher_if #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(512)) axi1 ();
  cache_line_fetcher_if #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(512)) axi4 ();

  cache_line_fetcher #(
    .TAGS_WIDTH(48), .CACHE_SIZE(512), .DATA_PORT_SIZE(512),
    .AXI_DATA_WIDTH(512), .AXI_ADDR_WIDTH(64), .MAX_OUTSTANDING(4)
  ) u_dut1 (
    .clk(clk), .rstn(rstn),
    .req_tvalid(req_tvalid1), .req_tready(req_tready1), .req_tdata(req_tdata1),
    .line_tvalid(line_tvalid1), .line_tready(line_tready1), .line_tdata(line_tdata1),
    .line_tlast(line_tlast1), .axi(axi1), .outstanding(outstanding1)
`ifdef CACHE_FETCH_ERR_EN
    , .err_sticky(err_sticky1), .err_count(err_count1)
`endif
  );

  cache_line_fetcher #(
    .TAGS_WIDTH(48), .CACHE_SIZE(2048), .DATA_PORT_SIZE(512),
    .AXI_DATA_WIDTH(512), .AXI_ADDR_WIDTH(64), .MAX_OUTSTANDING(4)
  ) u_dut4 (
    .clk(clk), .rstn(rstn),
    .req_tvalid(req_tvalid4), .req_tready(req_tready4), .req_tdata(req_tdata4),
    .line_tvalid(line_tvalid4), .line_tready(line_tready4), .line_tdata(line_tdata4),
    .line_tlast(line_tlast4), .axi(axi4), .outstanding(outstanding4)
`ifdef CACHE_FETCH_ERR_EN
    , .err_sticky(err_sticky4), .err_count(err_count4)
`endif
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one R beat on the 1-beat instance and hold it until accepted.
  task automatic beat1(input logic [511:0] d);
    logic got = 1'b0;
    exp_t e;
    axi1.m_axi_rvalid = 1'b1;
    axi1.m_axi_rdata  = d;
    axi1.m_axi_rlast  = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (axi1.m_axi_rready === 1'b1) begin
        got = 1'b1;
        e.data = d;
        e.last = 1'b1;
        q1.push_back(e);
      end
      tick();
    end
    axi1.m_axi_rvalid = 1'b0;
    axi1.m_axi_rlast  = 1'b0;
    check("beat1_handshake", 512'(got), 512'(1));
  endtask

  task automatic beat4(input logic [511:0] d, input logic l, input logic [1:0] resp);
    logic got = 1'b0;
    exp_t e;
    axi4.m_axi_rvalid = 1'b1;
    axi4.m_axi_rdata  = d;
    axi4.m_axi_rlast  = l;
    axi4.m_axi_rresp  = resp;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (axi4.m_axi_rready === 1'b1) begin
        got = 1'b1;
        e.data = d;
        e.last = (idx4 == 3);
        q4.push_back(e);
        idx4 = (idx4 + 1) % 4;
      end
      tick();
    end
    axi4.m_axi_rvalid = 1'b0;
    axi4.m_axi_rlast  = 1'b0;
    axi4.m_axi_rresp  = 2'b00;
    check("beat4_handshake", 512'(got), 512'(1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (n < 50 && (q1.size() != 0 || q4.size() != 0 ||
                      line_tvalid1 === 1'b1 || line_tvalid4 === 1'b1)) begin
      tick();
      n++;
    end
    @(negedge clk);
    check("drain_scoreboard", 512'(q1.size() + q4.size()), 512'(0));
  endtask

  // Output monitors: every accepted line beat must match the head of its scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rstn === 1'b1 && line_tvalid1 === 1'b1 && line_tready1 === 1'b1) begin
      check("line1_expected", 512'(q1.size() != 0), 512'(1));
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("line1_data", line_tdata1, e.data);
        check("line1_last", 512'(line_tlast1), 512'(e.last));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rstn === 1'b1 && line_tvalid4 === 1'b1 && line_tready4 === 1'b1) begin
      check("line4_expected", 512'(q4.size() != 0), 512'(1));
      if (q4.size() != 0) begin
        e = q4.pop_front();
        check("line4_data", line_tdata4, e.data);
        check("line4_last", 512'(line_tlast4), 512'(e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int occ;
    int k;
    logic push_h, pop_h;

    rstn = 1'b0;
    idx4 = 0;
    req_tvalid1 = 1'b0; req_tdata1 = '0; line_tready1 = 1'b0;
    req_tvalid4 = 1'b0; req_tdata4 = '0; line_tready4 = 1'b0;
    axi1.m_axi_arready = 1'b0; axi1.m_axi_rvalid = 1'b0; axi1.m_axi_rdata = '0;
    axi1.m_axi_rresp = 2'b00; axi1.m_axi_rlast = 1'b0;
    axi4.m_axi_arready = 1'b0; axi4.m_axi_rvalid = 1'b0; axi4.m_axi_rdata = '0;
    axi4.m_axi_rresp = 2'b00; axi4.m_axi_rlast = 1'b0;

    // Reset state
    repeat (2) tick();
    @(negedge clk);
    check("rst_req_tready",  512'(req_tready1), 512'(0));
    check("rst_arvalid",     512'(axi1.m_axi_arvalid), 512'(0));
    check("rst_rready",      512'(axi1.m_axi_rready), 512'(0));
    check("rst_line_tvalid", 512'(line_tvalid1), 512'(0));
    check("rst_line_tlast",  512'(line_tlast1), 512'(0));
    check("rst_line_tdata",  line_tdata1, 512'(0));
    check("rst_outstanding", 512'(outstanding1), 512'(0));
    check("rst_araddr4",     512'(axi4.m_axi_araddr), 512'(0));
    check("rst_arlen4",      512'(axi4.m_axi_arlen), 512'(0));
    tick();
    rstn = 1'b1;
    line_tready1 = 1'b1;
    axi1.m_axi_arready = 1'b1;
    @(negedge clk);
    check("rel_req_tready", 512'(req_tready1), 512'(1));

    // Single miss, 1-beat line
    tick();
    req_tvalid1 = 1'b1; req_tdata1 = 48'h1;
    @(negedge clk);
    check("t1_req_tready", 512'(req_tready1), 512'(1));
    tick();
    req_tvalid1 = 1'b0;
    @(negedge clk);
    check("t1_arvalid",     512'(axi1.m_axi_arvalid), 512'(1));
    check("t1_araddr",      512'(axi1.m_axi_araddr), 512'(64'h40));
    check("t1_arlen",       512'(axi1.m_axi_arlen), 512'(0));
    check("t1_arsize",      512'(axi1.m_axi_arsize), 512'(6));
    check("t1_arburst",     512'(axi1.m_axi_arburst), 512'(1));
    check("t1_arid",        512'(axi1.m_axi_arid), 512'(0));
    check("t1_outstanding", 512'(outstanding1), 512'(1));
    tick();
    axi1.m_axi_rvalid = 1'b1; axi1.m_axi_rdata = 512'hA5; axi1.m_axi_rlast = 1'b1;
    begin exp_t e; e.data = 512'hA5; e.last = 1'b1; q1.push_back(e); end
    @(negedge clk);
    check("t1_arvalid_drop", 512'(axi1.m_axi_arvalid), 512'(0));
    check("t1_rready",       512'(axi1.m_axi_rready), 512'(1));
    check("t1_tvalid_pre",   512'(line_tvalid1), 512'(0));
    tick();
    axi1.m_axi_rvalid = 1'b0; axi1.m_axi_rlast = 1'b0;
    @(negedge clk);
    check("t1_tvalid_post",  512'(line_tvalid1), 512'(1));
    check("t1_tlast",        512'(line_tlast1), 512'(1));
    check("t1_out_zero",     512'(outstanding1), 512'(0));
    tick();
    @(negedge clk);
    check("t1_tvalid_gone",  512'(line_tvalid1), 512'(0));

    // Outstanding limit
    for (int i = 0; i < 5; i++) begin
      tick();
      req_tvalid1 = 1'b1; req_tdata1 = 48'(16 + i);
      @(negedge clk);
      check("t2_req_tready", 512'(req_tready1), 512'(i < 4));
      if (i > 0) check("t2_araddr", 512'(axi1.m_axi_araddr), 512'(64'(15 + i) << 6));
    end
    check("t2_out_full", 512'(outstanding1), 512'(4));
    tick();
    axi1.m_axi_rvalid = 1'b1; axi1.m_axi_rdata = 512'hC0; axi1.m_axi_rlast = 1'b1;
    begin exp_t e; e.data = 512'hC0; e.last = 1'b1; q1.push_back(e); end
    @(negedge clk);
    check("t2_still_blocked", 512'(req_tready1), 512'(0));
    check("t2_rready",        512'(axi1.m_axi_rready), 512'(1));
    tick();
    axi1.m_axi_rvalid = 1'b0; axi1.m_axi_rlast = 1'b0;
    @(negedge clk);
    check("t2_out_dec",   512'(outstanding1), 512'(3));
    check("t2_reenabled", 512'(req_tready1), 512'(1));
    tick();
    req_tvalid1 = 1'b0;
    @(negedge clk);
    check("t2_out_refill", 512'(outstanding1), 512'(4));
    check("t2_araddr_5th", 512'(axi1.m_axi_araddr), 512'(64'(20) << 6));
    tick();
    for (int b = 0; b < 4; b++) beat1(512'hC1 + 512'(b));
    wait_drain();
    check("t2_out_empty", 512'(outstanding1), 512'(0));

    // AR stall
    tick();
    axi1.m_axi_arready = 1'b0;
    req_tvalid1 = 1'b1; req_tdata1 = 48'h20;
    @(negedge clk);
    check("t3_first_ready", 512'(req_tready1), 512'(1));
    tick();
    req_tdata1 = 48'h21;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("t3_arvalid_hold", 512'(axi1.m_axi_arvalid), 512'(1));
      check("t3_araddr_hold",  512'(axi1.m_axi_araddr), 512'(64'h800));
      check("t3_ready_low",    512'(req_tready1), 512'(0));
      tick();
    end
    axi1.m_axi_arready = 1'b1;
    @(negedge clk);
    check("t3_same_cycle", 512'(req_tready1), 512'(1));
    tick();
    req_tvalid1 = 1'b0;
    @(negedge clk);
    check("t3_arvalid_next", 512'(axi1.m_axi_arvalid), 512'(1));
    check("t3_araddr_next",  512'(axi1.m_axi_araddr), 512'(64'h840));
    check("t3_outstanding",  512'(outstanding1), 512'(2));
    tick();
    @(negedge clk);
    check("t3_arvalid_drop", 512'(axi1.m_axi_arvalid), 512'(0));
    tick();
    beat1(512'hD0);
    beat1(512'hD1);
    wait_drain();
    check("t3_out_empty", 512'(outstanding1), 512'(0));

    // Output backpressure on a 4-beat line
    tick();
    axi4.m_axi_arready = 1'b1;
    req_tvalid4 = 1'b1; req_tdata4 = 48'h3;
    @(negedge clk);
    check("t4_req_tready", 512'(req_tready4), 512'(1));
    tick();
    req_tvalid4 = 1'b0;
    @(negedge clk);
    check("t4_araddr",      512'(axi4.m_axi_araddr), 512'(64'h300));
    check("t4_arlen",       512'(axi4.m_axi_arlen), 512'(3));
    check("t4_arsize",      512'(axi4.m_axi_arsize), 512'(6));
    check("t4_outstanding", 512'(outstanding4), 512'(1));
    tick();
    occ = 0;
    k = 0;
    for (int c = 0; c < 60 && !(k == 4 && occ == 0); c++) begin
      axi4.m_axi_rvalid = (k < 4);
      axi4.m_axi_rdata  = 512'hB0 + 512'(k);
      axi4.m_axi_rlast  = (k == 3);
      line_tready4      = (c % 2 == 0);
      @(negedge clk);
      check("t4_rready", 512'(axi4.m_axi_rready), 512'(occ < 2));
      check("t4_tvalid", 512'(line_tvalid4), 512'(occ != 0));
      push_h = axi4.m_axi_rvalid & axi4.m_axi_rready;
      pop_h  = line_tvalid4 & line_tready4;
      if (push_h) begin
        exp_t e;
        e.data = axi4.m_axi_rdata;
        e.last = (idx4 == 3);
        q4.push_back(e);
        idx4 = (idx4 + 1) % 4;
        k++;
      end
      tick();
      occ = occ + int'(push_h) - int'(pop_h);
    end
    axi4.m_axi_rvalid = 1'b0; axi4.m_axi_rlast = 1'b0;
    line_tready4 = 1'b1;
    check("t4_all_beats", 512'(k), 512'(4));
    wait_drain();
    check("t4_out_empty", 512'(outstanding4), 512'(0));

    // Reset in the middle of a burst
    tick();
    line_tready4 = 1'b0;
    req_tvalid4 = 1'b1; req_tdata4 = 48'h5;
    @(negedge clk);
    check("t5_req_tready", 512'(req_tready4), 512'(1));
    tick();
    req_tvalid4 = 1'b0;
    beat4(512'hE0, 1'b0, 2'b00);
    beat4(512'hE1, 1'b0, 2'b00);
    @(negedge clk);
    check("t5_pre_tvalid", 512'(line_tvalid4), 512'(1));
    tick();
    rstn = 1'b0;
    q4.delete();
    idx4 = 0;
    tick();
    @(negedge clk);
    check("t5_tvalid",      512'(line_tvalid4), 512'(0));
    check("t5_outstanding", 512'(outstanding4), 512'(0));
    check("t5_arvalid",     512'(axi4.m_axi_arvalid), 512'(0));
    check("t5_tlast",       512'(line_tlast4), 512'(0));
    check("t5_tdata",       line_tdata4, 512'(0));
    check("t5_req_tready",  512'(req_tready4), 512'(0));
    check("t5_rready",      512'(axi4.m_axi_rready), 512'(0));
    tick();
    rstn = 1'b1;
    line_tready4 = 1'b1;
    req_tvalid4 = 1'b1; req_tdata4 = 48'h6;
    @(negedge clk);
    check("t5_req_after", 512'(req_tready4), 512'(1));
    tick();
    req_tvalid4 = 1'b0;
    @(negedge clk);
    check("t5_araddr", 512'(axi4.m_axi_araddr), 512'(64'h600));
    tick();
    for (int b = 0; b < 4; b++) beat4(512'hF0 + 512'(b), (b == 3), 2'b00);
    wait_drain();
    check("t5_out_empty", 512'(outstanding4), 512'(0));

`ifdef CACHE_FETCH_ERR_EN
    // Error reporting: one bad rresp and one early rlast
    check("t6_sticky_clear", 512'(err_sticky4), 512'(0));
    check("t6_count_clear",  512'(err_count4), 512'(0));
    tick();
    req_tvalid4 = 1'b1; req_tdata4 = 48'h7;
    @(negedge clk);
    check("t6_req_tready", 512'(req_tready4), 512'(1));
    tick();
    req_tvalid4 = 1'b0;
    beat4(512'h1111, 1'b0, 2'b10);
    beat4(512'h2222, 1'b1, 2'b00);
    beat4(512'h3333, 1'b0, 2'b00);
    beat4(512'h4444, 1'b1, 2'b00);
    wait_drain();
    check("t6_sticky", 512'(err_sticky4), 512'(1));
    check("t6_count",  512'(err_count4), 512'(2));
    check("t6_out",    512'(outstanding4), 512'(0));
    check("t6_dut1_clean", 512'(err_count1), 512'(0));
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
